ascon_round_sequencer: RTL and testbench
========================================

ASCON_ROUND_SEQUENCER -- requirements
Module: ascon_round_sequencer

Interface
REQ-001 The block SHALL have no parameters; round constants SHALL come from the 12-entry round_constant table in ascon_pack (F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B).
REQ-002 clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request to start a permutation run; sampled in IDLE only.
REQ-005 mode_i  input  2  round count: 00 = p12, 01 = p8, 10 = p6, 11 = treated as p12.
REQ-006 stall_i  input  1  hold current round; no advance while high.
REQ-007 abort_i  input  1  cancel the current run.
REQ-008 rc_o  output  8  round constant for the current round.
REQ-009 round_o  output  4  current table index, 0..11.
REQ-010 valid_o  output  1  rc_o/round_o describe a round to execute this cycle.
REQ-011 last_o  output  1  current round is the final round (round_o = 11) and valid_o = 1.
REQ-012 busy_o  output  1  high in RUN and DONE.
REQ-013 done_o  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE -> RUN when start_i = 1 and abort_i = 0; round_o SHALL load the start index: 0 (p12), 4 (p8), 6 (p6), 0 (mode 11).
REQ-016 In RUN: valid_o = 1, rc_o = round_constant[round_o], busy_o = 1.
REQ-017 In RUN with stall_i = 0 and abort_i = 0: if round_o < 11, round_o SHALL increment by 1; if round_o = 11, next state SHALL be DONE.
REQ-018 In RUN with stall_i = 1 and abort_i = 0: state, round_o, rc_o, valid_o, last_o SHALL hold unchanged.
REQ-019 abort_i = 1 in RUN SHALL force IDLE on the next edge, overriding stall_i; done_o SHALL NOT pulse for an aborted run.
REQ-020 DONE SHALL last exactly one cycle with done_o = 1, valid_o = 0, then return to IDLE unconditionally; abort_i and stall_i SHALL be ignored in DONE.
REQ-021 start_i in RUN or DONE SHALL be ignored; mode_i SHALL be sampled only on the accepting edge, and later changes SHALL NOT affect the run.
REQ-022 start_i and abort_i both high in IDLE: the FSM SHALL remain in IDLE.
REQ-023 Latency: with start accepted at edge t and no stall, first valid cycle SHALL follow edge t; p12/p8/p6 SHALL give 12/8/6 consecutive valid cycles; done_o SHALL be high the cycle after the last valid cycle.
REQ-024 round_o SHALL never exceed 11 and SHALL never wrap to 0 inside a run.
REQ-025 In IDLE: rc_o = 8'h00, round_o = 0, valid_o = last_o = busy_o = done_o = 0.
REQ-026 All outputs SHALL be registered or decoded solely from registered state; no combinational path from any input to any output.

Reset
REQ-027 reset_i = 1 SHALL force IDLE on the next edge with all outputs at REQ-025 values, from any state, with priority over every other input.
REQ-028 Reset mid-run SHALL discard the run with no done_o pulse; start_i during reset SHALL be ignored.

Verification
REQ-029 Reset, start_i = 1 with mode 00, no stall -> 12 valid cycles, rc_o sequence F0..4B, last_o only with rc_o = 4B, then done_o one cycle, then IDLE.
REQ-030 start with mode 10 -> round_o 6..11, rc_o 96,87,78,69,5A,4B, done_o one cycle later; mode 01 -> round_o 4..11, first rc_o B4.
REQ-031 p12 run, stall_i high for 3 cycles at round_o = 5 -> rc_o = A5 held 4 cycles total, run ends with done_o on the 16th cycle after start.
REQ-032 p12 run, abort_i at round_o = 7 (also with stall_i = 1) -> IDLE next cycle, outputs at idle values, no done_o; new start then runs normally.
REQ-033 reset_i asserted at round_o = 9 -> IDLE next edge, no done_o; start_i held high during reset not accepted until the first cycle after reset release.
REQ-034 start_i held high continuously with mode 10 -> back-to-back runs: each run 6 valid cycles + 1 DONE cycle, then 1 IDLE cycle before the next run begins.

Source files
------------

// File: rtl/ascon_round_sequencer.sv
// Ascon permutation round sequencer: walks the round-constant
// table for p12/p8/p6 runs with stall, abort and done handshake.
//
// Ports:
//   clock_i  - single clock, rising edge
//   reset_i  - synchronous active-high reset
//   start_i  - start a run (sampled in IDLE only)
//   mode_i   - 00 p12, 01 p8, 10 p6, 11 p12
//   stall_i  - hold the current round
//   abort_i  - cancel the current run
//   rc_o     - round constant of the current round
//   round_o  - current table index 0..11
//   valid_o  - a round executes this cycle
//   last_o   - current round is index 11
//   busy_o   - run or completion in progress
//   done_o   - one-cycle completion pulse

package ascon_pack;

   localparam logic [7:0] round_constant [12] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3,
      8'hB4, 8'hA5, 8'h96, 8'h87,
      8'h78, 8'h69, 8'h5A, 8'h4B
   };

endpackage

module ascon_round_sequencer
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [1:0] mode_i,
   input  logic       stall_i,
   input  logic       abort_i,
   output logic [7:0] rc_o,
   output logic [3:0] round_o,
   output logic       valid_o,
   output logic       last_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t     state;
   logic [3:0] round;
   logic [3:0] start_idx;

   // Shorter permutations use the tail of the table.
   always_comb begin
      start_idx = 4'd0;
      unique case (1'b1)
         (mode_i == 2'b01): start_idx = 4'd4;
         (mode_i == 2'b10): start_idx = 4'd6;
         default:           start_idx = 4'd0;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
         round <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_i && !abort_i) begin
                  state <= RUN;
                  round <= start_idx;
               end
            end
            RUN: begin
               // Abort wins over stall.
               if (abort_i) begin
                  state <= IDLE;
                  round <= 4'd0;
               end else if (!stall_i) begin
                  if (round == 4'd11) begin
                     state <= DONE;
                     round <= 4'd0;
                  end else begin
                     round <= round + 4'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               round <= 4'd0;
            end
            default: begin
               state <= IDLE;
               round <= 4'd0;
            end
         endcase
      end
   end

   // Outputs depend on registered state only.
   always_comb begin
      valid_o = (state == RUN);
      busy_o  = (state != IDLE);
      done_o  = (state == DONE);
      last_o  = valid_o && (round == 4'd11);
      round_o = round;
      rc_o    = valid_o ? round_constant[round] : 8'h00;
   end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Self-checking bench for ascon_round_sequencer: directed
// scenarios plus random traffic against a schedule-queue model.

module tb_ascon_round_sequencer;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] mode_i = 2'b00;
   logic       stall_i = 1'b0;
   logic       abort_i = 1'b0;
   logic [7:0] rc_o;
   logic [3:0] round_o;
   logic       valid_o;
   logic       last_o;
   logic       busy_o;
   logic       done_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] tbl [12] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3,
      8'hB4, 8'hA5, 8'h96, 8'h87,
      8'h78, 8'h69, 8'h5A, 8'h4B
   };

   // Model: queue of table indices still to execute,
   // plus a flag for the completion cycle.
   int sched[$];
   bit done_m = 1'b0;

   always #5 clk = ~clk;

   ascon_round_sequencer dut (
      .clock_i (clk),
      .reset_i (reset_i),
      .start_i (start_i),
      .mode_i  (mode_i),
      .stall_i (stall_i),
      .abort_i (abort_i),
      .rc_o    (rc_o),
      .round_o (round_o),
      .valid_o (valid_o),
      .last_o  (last_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   task automatic chk(string tag, logic [7:0] obs,
                      logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   function automatic int first_idx(logic [1:0] m);
      if (m == 2'b01) return 4;
      if (m == 2'b10) return 6;
      return 0;
   endfunction

   function automatic void model_edge();
      if (reset_i) begin
         sched.delete();
         done_m = 1'b0;
      end else if (sched.size() > 0) begin
         if (abort_i) begin
            sched.delete();
         end else if (!stall_i) begin
            void'(sched.pop_front());
            if (sched.size() == 0) done_m = 1'b1;
         end
      end else if (done_m) begin
         done_m = 1'b0;
      end else if (start_i && !abort_i) begin
         for (int i = first_idx(mode_i); i < 12; i++)
            sched.push_back(i);
      end
   endfunction

   task automatic check_all();
      if (sched.size() > 0) begin
         chk("valid", {7'd0, valid_o}, 8'd1);
         chk("round", {4'd0, round_o}, 8'(sched[0]));
         chk("rc", rc_o, tbl[sched[0]]);
         chk("last", {7'd0, last_o},
             {7'd0, sched[0] == 11});
         chk("busy", {7'd0, busy_o}, 8'd1);
         chk("done", {7'd0, done_o}, 8'd0);
      end else if (done_m) begin
         chk("valid_d", {7'd0, valid_o}, 8'd0);
         chk("last_d", {7'd0, last_o}, 8'd0);
         chk("busy_d", {7'd0, busy_o}, 8'd1);
         chk("done_d", {7'd0, done_o}, 8'd1);
      end else begin
         chk("valid_i", {7'd0, valid_o}, 8'd0);
         chk("round_i", {4'd0, round_o}, 8'd0);
         chk("rc_i", rc_o, 8'h00);
         chk("last_i", {7'd0, last_o}, 8'd0);
         chk("busy_i", {7'd0, busy_o}, 8'd0);
         chk("done_i", {7'd0, done_o}, 8'd0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_in();
      reset_i = 1'b0;
      start_i = 1'b0;
      stall_i = 1'b0;
      abort_i = 1'b0;
   endtask

   // Run a whole job and check its length and done position.
   task automatic full_run(logic [1:0] m, int nval);
      int vcnt;
      int dpos;
      vcnt = 0;
      dpos = 0;
      mode_i = m;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      mode_i = ~m;
      for (int k = 1; k <= 20; k++) begin
         if (valid_o === 1'b1) vcnt++;
         if (done_o === 1'b1 && dpos == 0) dpos = k;
         step();
      end
      chk("run_len", 8'(vcnt), 8'(nval));
      chk("done_pos", 8'(dpos), 8'(nval + 1));
   endtask

   initial begin
      int dpos;
      int hold;
      idle_in();
      reset_i = 1'b1;
      start_i = 1'b1;
      step();
      step();
      idle_in();
      step();

      full_run(2'b00, 12);
      full_run(2'b10, 6);
      full_run(2'b01, 8);
      full_run(2'b11, 12);

      // Stall three cycles at round 5.
      mode_i = 2'b00;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      dpos = 0;
      hold = 0;
      for (int k = 1; k <= 24; k++) begin
         if (rc_o === 8'hA5) hold++;
         if (done_o === 1'b1 && dpos == 0) dpos = k;
         stall_i = (sched.size() > 0 && sched[0] == 5
                    && hold < 4);
         step();
      end
      chk("stall_hold", 8'(hold), 8'd4);
      chk("stall_done", 8'(dpos), 8'd16);
      idle_in();

      // Abort at round 7 together with stall.
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (sched.size() > 0 && sched[0] == 7) break;
         step();
      end
      chk("at_r7", {4'd0, round_o}, 8'd7);
      abort_i = 1'b1;
      stall_i = 1'b1;
      step();
      idle_in();
      for (int k = 0; k < 4; k++) step();
      full_run(2'b00, 12);

      // Reset at round 9 with start held high.
      start_i = 1'b1;
      step();
      for (int k = 0; k < 20; k++) begin
         if (sched.size() > 0 && sched[0] == 9) break;
         step();
      end
      chk("at_r9", {4'd0, round_o}, 8'd9);
      reset_i = 1'b1;
      step();
      step();
      reset_i = 1'b0;
      step();
      chk("post_rst_run", {7'd0, valid_o}, 8'd1);
      idle_in();
      for (int k = 0; k < 14; k++) step();

      // Back-to-back p6 runs with start held.
      mode_i = 2'b10;
      start_i = 1'b1;
      for (int k = 0; k < 24; k++) step();
      idle_in();
      for (int k = 0; k < 10; k++) step();

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         reset_i = ($urandom_range(0, 49) == 0);
         start_i = ($urandom_range(0, 1) == 1);
         mode_i  = 2'($urandom_range(0, 3));
         stall_i = ($urandom_range(0, 4) == 0);
         abort_i = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
